// File: rtl/mem_msg_pkg.sv
// Shared definitions for the memory request/response protocol.
// This package holds the op encoding, the default-width message structs and
// the byte-mask helper used for partial-word writes.
package mem_msg_pkg;

    typedef enum logic {
        MEM_MSG_READ  = 1'b0,
        MEM_MSG_WRITE = 1'b1
    } mem_msg_op_e;

    // Default message field widths. A module built with other widths
    // declares structs of the same shape from its own parameters.
    localparam int MEM_ADDR_BITS = 32;
    localparam int MEM_DATA_BITS = 32;
    localparam int MEM_OPAQ_BITS = 8;
    localparam int MEM_LEN_BITS  = MEM_DATA_BITS / 8;

    // Widest word, in bytes, that the mask helper can describe.
    localparam int MEM_MAX_BYTES = 16;

    typedef struct packed {
        mem_msg_op_e              op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [MEM_LEN_BITS-1:0]  len;
        logic [MEM_DATA_BITS-1:0] data;
    } mem_req_msg_t;

    typedef struct packed {
        mem_msg_op_e              op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [MEM_LEN_BITS-1:0]  len;
        logic [MEM_DATA_BITS-1:0] data;
    } mem_resp_msg_t;

    // Byte enables for an access of len bytes starting at byte offset within
    // a word of nbytes bytes. A len of 0 selects the whole word. Bytes that
    // would fall past the end of the word are dropped, never wrapped.
    function automatic logic [MEM_MAX_BYTES-1:0] mem_byte_mask(
        input int unsigned len,
        input int unsigned offset,
        input int unsigned nbytes
    );
        logic [MEM_MAX_BYTES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MEM_MAX_BYTES; i++) begin
            if (i < nbytes) begin
                if (len == 0) begin
                    mask[i] = 1'b1;
                end else if ((i >= offset) && (i < offset + len)) begin
                    mask[i] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_resp_queue.sv
// Generic valid/ready FIFO of messages.
// Entries are registered: a pushed message becomes visible at deq the cycle
// after the push. A full queue still accepts a push when it is popped in the
// same cycle, so enq_rdy looks at deq_rdy.
//
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high; the sender holds valid and payload steady until that edge, and
// valid never waits on ready.
module mem_resp_queue #(
    parameter int  p_depth = 4,
    parameter type msg_t   = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic enq_val,
    output logic enq_rdy,
    input  msg_t enq_msg,
    output logic deq_val,
    input  logic deq_rdy,
    output msg_t deq_msg
);

    localparam int PTR_BITS = (p_depth > 1) ? $clog2(p_depth) : 1;

    msg_t                entries_q [p_depth];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic                full_q, full_d;
    logic                empty;
    logic                do_enq, do_deq;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(p_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (wr_ptr_q == rd_ptr_q) && !full_q;
    assign deq_val = !empty;
    assign enq_rdy = !full_q || deq_rdy;
    assign do_enq  = enq_val && enq_rdy;
    assign do_deq  = deq_val && deq_rdy;
    assign deq_msg = entries_q[rd_ptr_q];

    // Next pointers and full flag from the push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        if (do_enq) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_deq) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_enq && !do_deq) begin
            full_d = (ptr_inc(wr_ptr_q) == rd_ptr_q);
        end else if (do_deq && !do_enq) begin
            full_d = 1'b0;
        end
    end

    // Pointer and flag registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
        end
    end

    // Entry storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            entries_q[wr_ptr_q] <= enq_msg;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Functional memory server for the request/response protocol.
// Storage is accessed in the accept cycle (reads sample the word, writes
// update it at the accept edge). The response then travels through
// p_latency-1 register stages and the registered response queue, so the
// earliest resp_val is exactly p_latency cycles after accept. A credit
// counter over pipeline plus queue keeps the queue from ever overflowing.
//
// Handshake: req transfers on req_val & req_rdy, resp on resp_val & resp_rdy
// at the clock edge; req_rdy depends only on state, resp_val only on queue
// contents.
module mem_responder
    import mem_msg_pkg::*;
#(
    parameter int p_addr_bits  = 32,
    parameter int p_data_bits  = 32,
    parameter int p_opaq_bits  = 8,
    parameter int p_mem_words  = 1024,
    parameter int p_latency    = 2,
    parameter int p_resp_depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_op,
    input  logic [p_opaq_bits-1:0]   req_opaque,
    input  logic [p_addr_bits-1:0]   req_addr,
    input  logic [p_data_bits/8-1:0] req_len,
    input  logic [p_data_bits-1:0]   req_data,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_op,
    output logic [p_opaq_bits-1:0]   resp_opaque,
    output logic [p_addr_bits-1:0]   resp_addr,
    output logic [p_data_bits/8-1:0] resp_len,
    output logic [p_data_bits-1:0]   resp_data
);

    localparam int NBYTES    = p_data_bits / 8;
    localparam int OFF_BITS  = $clog2(NBYTES);
    localparam int IDX_BITS  = $clog2(p_mem_words);
    localparam int CRED_BITS = $clog2(p_resp_depth) + 1;
    localparam int STAGES    = p_latency - 1;

    typedef struct packed {
        logic                   op;
        logic [p_opaq_bits-1:0] opaque;
        logic [p_addr_bits-1:0] addr;
        logic [NBYTES-1:0]      len;
        logic [p_data_bits-1:0] data;
    } resp_msg_t;

    typedef struct packed {
        logic      val;
        resp_msg_t msg;
    } stage_t;

    logic [p_data_bits-1:0]   mem_q [p_mem_words];
    logic                     req_xfer;
    logic                     resp_xfer;
    logic [IDX_BITS-1:0]      word_idx;
    logic [OFF_BITS-1:0]      byte_off;
    logic [MEM_MAX_BYTES-1:0] mask_full;
    logic                     unused_mask_par;
    logic [NBYTES-1:0]        wr_mask;
    logic [p_data_bits-1:0]   wr_data;
    logic                     wr_en;
    stage_t                   acc_stage;
    stage_t                   push_stage;
    logic [CRED_BITS-1:0]     credits_q, credits_d;
    logic                     q_enq_rdy;
    resp_msg_t                q_deq_msg;

    assign req_rdy   = credits_q < CRED_BITS'(p_resp_depth);
    assign req_xfer  = req_val && req_rdy;
    assign resp_xfer = resp_val && resp_rdy;

    // Word index ignores the upper address bits, so addresses wrap.
    assign word_idx = req_addr[OFF_BITS +: IDX_BITS];
    assign byte_off = req_addr[OFF_BITS-1:0];

    // Decode the accepted request: write enables, aligned write data and the
    // response message that enters the latency pipeline.
    always_comb begin
        mask_full = mem_byte_mask(32'(req_len), 32'(byte_off), 32'(NBYTES));
        wr_mask   = mask_full[NBYTES-1:0];
        // Partial writes take data starting at byte 0 of req_data and land it
        // at the addressed offset; a full-word write ignores the offset.
        wr_data   = (req_len == '0) ? req_data : (req_data << (8 * byte_off));
        wr_en     = req_xfer && (req_op == MEM_MSG_WRITE) && !rst;

        acc_stage            = '0;
        acc_stage.val        = req_xfer;
        acc_stage.msg.op     = req_op;
        acc_stage.msg.opaque = req_opaque;
        acc_stage.msg.addr   = req_addr;
        acc_stage.msg.len    = req_len;
        acc_stage.msg.data   = (req_op == MEM_MSG_WRITE) ? '0 : mem_q[word_idx];
    end

    assign unused_mask_par = ^mask_full;

    // Storage update at the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_mask[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    if (STAGES == 0) begin : g_no_pipe
        assign push_stage = acc_stage;
    end else begin : g_pipe
        stage_t pipe_q [STAGES];
        stage_t pipe_d [STAGES];

        // Shift every cycle regardless of backpressure; credits bound it.
        always_comb begin
            pipe_d[0] = acc_stage;
            for (int i = 1; i < STAGES; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        // Pipeline registers; reset drops anything in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < STAGES; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < STAGES; i++) begin
                    pipe_q[i] <= pipe_d[i];
                end
            end
        end

        assign push_stage = pipe_q[STAGES-1];
    end

    mem_resp_queue #(
        .p_depth (p_resp_depth),
        .msg_t   (resp_msg_t)
    ) u_resp_queue (
        .clk     (clk),
        .rst     (rst),
        .enq_val (push_stage.val),
        .enq_rdy (q_enq_rdy),
        .enq_msg (push_stage.msg),
        .deq_val (resp_val),
        .deq_rdy (resp_rdy),
        .deq_msg (q_deq_msg)
    );

    assign resp_op     = q_deq_msg.op;
    assign resp_opaque = q_deq_msg.opaque;
    assign resp_addr   = q_deq_msg.addr;
    assign resp_len    = q_deq_msg.len;
    assign resp_data   = q_deq_msg.data;

    // Credits track responses owed: up on accept, down on delivery.
    always_comb begin
        credits_d = credits_q;
        case ({req_xfer, resp_xfer})
            2'b10:   credits_d = credits_q + 1'b1;
            2'b01:   credits_d = credits_q - 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // Credit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= '0;
        end else begin
            credits_q <= credits_d;
        end
    end

    queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push_stage.val |-> q_enq_rdy)
        else $error("mem_responder response queue overflow");

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written multi-cycle
// sequences and a randomized phase, all checked against a byte-level memory
// model and an in-order expected-response queue.
module tb_mem_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int OW    = 8;
    localparam int NB    = DW / 8;
    localparam int WORDS = 1024;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int RW    = 1 + OW + AW + NB + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          req_val, req_rdy, req_op;
    logic [OW-1:0] req_opaque;
    logic [AW-1:0] req_addr;
    logic [NB-1:0] req_len;
    logic [DW-1:0] req_data;
    logic          resp_val, resp_rdy, resp_op;
    logic [OW-1:0] resp_opaque;
    logic [AW-1:0] resp_addr;
    logic [NB-1:0] resp_len;
    logic [DW-1:0] resp_data;

    mem_responder #(
        .p_addr_bits  (AW),
        .p_data_bits  (DW),
        .p_opaq_bits  (OW),
        .p_mem_words  (WORDS),
        .p_latency    (LAT),
        .p_resp_depth (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_op      (req_op),
        .req_opaque  (req_opaque),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_data    (req_data),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_op     (resp_op),
        .resp_opaque (resp_opaque),
        .resp_addr   (resp_addr),
        .resp_len    (resp_len),
        .resp_data   (resp_data)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int passes = 0;

    logic [RW-1:0] exp_q[$];
    int            resp_cyc_q[$];
    logic [7:0]    model_mem [WORDS][NB];

    task automatic check(input string nm, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic logic [RW-1:0] pack(input logic op, input logic [OW-1:0] opq,
                                           input logic [AW-1:0] addr, input logic [NB-1:0] len,
                                           input logic [DW-1:0] data);
        return {op, opq, addr, len, data};
    endfunction

    function automatic logic [DW-1:0] model_word(input logic [AW-1:0] addr);
        logic [DW-1:0] w;
        int idx;
        idx = int'((addr >> 2) % WORDS);
        for (int b = 0; b < NB; b++) w[8*b +: 8] = model_mem[idx][b];
        return w;
    endfunction

    // Apply one accepted request to the model and return the response it owes.
    function automatic logic [RW-1:0] model_accept(input logic op, input logic [OW-1:0] opq,
                                                   input logic [AW-1:0] addr, input logic [NB-1:0] len,
                                                   input logic [DW-1:0] data);
        int idx;
        int off;
        idx = int'((addr >> 2) % WORDS);
        off = int'(addr % 4);
        if (op) begin
            if (len == 0) begin
                for (int b = 0; b < NB; b++) model_mem[idx][b] = data[8*b +: 8];
            end else begin
                for (int k = 0; k < int'(len); k++) begin
                    if (off + k < NB) model_mem[idx][off+k] = data[8*k +: 8];
                end
            end
            return pack(op, opq, addr, len, '0);
        end
        return pack(op, opq, addr, len, model_word(addr));
    endfunction

    // Monitor: record accepts into the expected queue, check every delivered response.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_val && req_rdy)
                exp_q.push_back(model_accept(req_op, req_opaque, req_addr, req_len, req_data));
            if (resp_val && resp_rdy) begin
                resp_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) check("resp_unexpected", {resp_op, resp_opaque}, '1);
                else check("resp_scoreboard", pack(resp_op, resp_opaque, resp_addr, resp_len, resp_data),
                           exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge.
    task automatic send(input logic op, input logic [AW-1:0] addr, input logic [NB-1:0] len,
                        input logic [DW-1:0] data, input logic [OW-1:0] opq, output int acc_cyc);
        int  n;
        logic ok;
        req_val = 1'b1; req_op = op; req_addr = addr; req_len = len; req_data = data; req_opaque = opq;
        n = 0; ok = 1'b0; acc_cyc = -1;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (req_rdy) begin ok = 1'b1; acc_cyc = cyc; end
            @(posedge clk); #1;
            n++;
        end
        req_val = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_resp(output logic [RW-1:0] got, output int rc);
        int  n;
        logic ok;
        n = 0; ok = 1'b0; got = '0; rc = -1;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (resp_val) begin
                ok = 1'b1;
                got = pack(resp_op, resp_opaque, resp_addr, resp_len, resp_data);
                rc = cyc;
            end
            n++;
        end
        @(posedge clk); #1;
        if (!ok) check("resp_timeout", 0, 1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        resp_rdy = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(nm, exp_q.size(), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          op;
        logic [AW-1:0] addr;
        logic [NB-1:0] len;
        logic [DW-1:0] data;
        logic [OW-1:0] opq;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [RW-1:0] got, got2;
        int acc, acc2, rc, rc2, stall, acc_n;
        logic pend;

        vecs[0]  = '{1'b1, 32'h0000_0040, 4'd0, 32'hDEAD_BEEF, 8'h01, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 4'd0, 32'h0,         8'h05, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0080, 4'd0, 32'h1122_3344, 8'h02, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0081, 4'd2, 32'h0000_AABB, 8'h03, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0080, 4'd0, 32'h0,         8'h04, 32'h11AA_BB44};
        vecs[5]  = '{1'b1, 32'h0000_0083, 4'd3, 32'h00CC_DDEE, 8'h06, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0080, 4'd0, 32'h0,         8'h07, 32'hEEAA_BB44};
        vecs[7]  = '{1'b1, 32'h0000_0080, 4'd1, 32'h1234_5699, 8'h08, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0080, 4'd0, 32'h0,         8'h09, 32'hEEAA_BB99};
        vecs[9]  = '{1'b1, 32'h0000_1000, 4'd0, 32'h0000_0001, 8'h0A, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0000, 4'd0, 32'h0,         8'h0B, 32'h0000_0001};
        vecs[11] = '{1'b0, 32'h0040_1000, 4'd0, 32'h0,         8'h0C, 32'h0000_0001};

        rst = 1'b1; req_val = 1'b0; req_op = 1'b0; req_opaque = '0; req_addr = '0;
        req_len = '0; req_data = '0; resp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_resp_val", resp_val, 0);
        check("reset_req_rdy", req_rdy, 1);
        @(posedge clk); #1;

        // Preload words 0..63 through the write path, back to back.
        for (int w = 0; w < 64; w++) send(1'b1, AW'(w * 4), '0, $urandom, OW'(w), acc);
        drain("preload_drain");

        // Table: one request at a time, check data, echoes and latency.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].opq, acc);
            wait_resp(got, rc);
            check($sformatf("vec%0d_data", i), got[DW-1:0], vecs[i].exp);
            check($sformatf("vec%0d_echo", i), got[RW-1:DW],
                  {vecs[i].op, vecs[i].opq, vecs[i].addr, vecs[i].len});
            check($sformatf("vec%0d_latency", i), rc - acc, LAT);
        end

        // Write then read of the same word on the very next cycle.
        send(1'b1, 32'h84, '0, 32'hCAFE_F00D, 8'h20, acc);
        send(1'b0, 32'h84, '0, '0, 8'h21, acc2);
        wait_resp(got, rc);
        wait_resp(got2, rc2);
        check("b2b_accept_gap", acc2 - acc, 1);
        check("b2b_write_data", got[DW-1:0], 0);
        check("b2b_read_data", got2[DW-1:0], 32'hCAFE_F00D);
        check("b2b_resp_gap", rc2 - rc, 1);

        // Streaming reads 0x0..0x3C with resp_rdy held high.
        resp_cyc_q.delete();
        stall = 0;
        for (int k = 0; k < 16; k++) begin
            req_val = 1'b1; req_op = 1'b0; req_addr = AW'(k * 4); req_len = '0; req_opaque = OW'(k);
            @(negedge clk);
            if (!req_rdy) stall++;
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        drain("stream_drain");
        check("stream_stalls", stall, 0);
        check("stream_resp_count", resp_cyc_q.size(), 16);
        if (resp_cyc_q.size() >= 16) check("stream_resp_span", resp_cyc_q[15] - resp_cyc_q[0], 15);

        // Backpressure: only DEPTH requests fit while responses are held.
        resp_rdy = 1'b0;
        acc_n = 0;
        for (int c = 0; c < 8; c++) begin
            req_val = 1'b1; req_op = 1'b0; req_addr = AW'(acc_n * 4); req_len = '0;
            req_opaque = OW'(8'h40 + acc_n);
            @(negedge clk);
            if (req_rdy) acc_n++;
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        check("bp_accepted", acc_n, DEPTH);
        @(negedge clk);
        check("bp_full_rdy", req_rdy, 0);
        @(posedge clk); #1 resp_rdy = 1'b1;
        @(posedge clk); #1 resp_rdy = 1'b0;
        @(negedge clk);
        check("bp_rdy_after_pop", req_rdy, 1);
        check("bp_pending", exp_q.size(), DEPTH - 1);
        @(posedge clk); #1;
        drain("bp_drain");

        // Reset with three responses queued and one in the pipeline.
        resp_rdy = 1'b0;
        for (int k = 0; k < 4; k++) send(1'b0, AW'(k * 4), '0, '0, OW'(8'h60 + k), acc);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_resp_val", resp_val, 0);
        check("rst_mid_req_rdy", req_rdy, 1);
        @(posedge clk); #1 resp_rdy = 1'b1;
        resp_cyc_q.delete();
        send(1'b0, 32'h40, '0, '0, 8'h77, acc);
        wait_resp(got, rc);
        check("rst_after_latency", rc - acc, LAT);
        check("rst_after_resp", got, pack(1'b0, 8'h77, 32'h40, '0, model_word(32'h40)));
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_stale", resp_cyc_q.size(), 1);

        // Randomized traffic with random backpressure; requests held until taken.
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!pend) begin
                if ($urandom_range(0, 9) < 7) begin
                    req_val    = 1'b1;
                    req_op     = 1'($urandom_range(0, 1));
                    req_addr   = ($urandom & 32'hFFFF_F000) | AW'($urandom_range(0, 255));
                    req_len    = NB'($urandom_range(0, 6));
                    req_data   = $urandom;
                    req_opaque = OW'($urandom);
                end else begin
                    req_val = 1'b0;
                end
            end
            resp_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            pend = req_val && !req_rdy;
        end
        @(posedge clk); #1 req_val = 1'b0;
        drain("random_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
